ap_window_feeder: RTL and testbench

Streaming front end for the arithmetic-progression detector. It accepts a byte stream over a valid/ready handshake and keeps a seven-sample sliding window. Each full window is presented as A..G (A oldest, G newest) with a valid/ready handshake, so the combinational detector sees a stable window for as long as the output is held. Frame boundaries (in_last) restart window filling, and frames that are too short are flagged.

---
 rtl/ap_window_feeder.sv | 133 +++++++++++++
 tb/tb_ap_window_feeder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ap_window_feeder.sv
// Seven-sample sliding window front end for the AP detector.
// Frames restart filling; short frames raise a one-cycle flag.
module ap_window_feeder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             win_valid,
  input  logic             win_ready,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] F,
  output logic [WIDTH-1:0] G,
  output logic             win_last,
  output logic [15:0]      win_index,
  output logic             short_frame
);

  typedef enum logic {FILLING, FULL} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [2:0]  fill_q;
  logic [2:0]  fill_d;
  logic [2:0]  fill_n;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        acc;
  logic        emit;
  logic        wv_d;
  logic        sf_d;

  // Accept only when the held window is gone or leaving now.
  assign in_ready = rst_n & ~clear & (~win_valid | win_ready);
  assign acc      = in_valid & in_ready;
  assign fill_n   = (fill_q == 3'd7) ? 3'd7 : fill_q + 3'd1;

  // Fill state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILLING;
      fill_q  <= 3'd0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
    end
  end

  // Next fill state: frame end or clear restarts filling.
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    unique case (1'b1)
      clear: begin
        state_d = FILLING;
        fill_d  = 3'd0;
      end
      acc & in_last: begin
        state_d = FILLING;
        fill_d  = 3'd0;
      end
      acc & ~in_last: begin
        fill_d  = fill_n;
        state_d = (fill_n == 3'd7) ? FULL : FILLING;
      end
      default: ;
    endcase
  end

  // Handshake, frame counter and short-frame outputs.
  always_comb begin
    emit = acc & (fill_n == 3'd7);
    sf_d = ~clear & acc & in_last & (fill_n != 3'd7);
    wv_d = 1'b0;
    cnt_d = cnt_q;
    if (clear) begin
      wv_d  = 1'b0;
      cnt_d = 16'd0;
    end else begin
      wv_d = emit | (win_valid & ~win_ready);
      if (acc & in_last)
        cnt_d = 16'd0;
      else if (emit && cnt_q != 16'hFFFF)
        cnt_d = cnt_q + 16'd1;
    end
  end

  // Window shift and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      A           <= '0;
      B           <= '0;
      C           <= '0;
      D           <= '0;
      E           <= '0;
      F           <= '0;
      G           <= '0;
      cnt_q       <= 16'd0;
      win_valid   <= 1'b0;
      win_last    <= 1'b0;
      win_index   <= 16'd0;
      short_frame <= 1'b0;
    end else begin
      if (acc) begin
        A <= B;
        B <= C;
        C <= D;
        D <= E;
        E <= F;
        F <= G;
        G <= in_data;
      end
      cnt_q       <= cnt_d;
      win_valid   <= wv_d;
      short_frame <= sf_d;
      if (clear)
        win_last <= 1'b0;
      else if (emit)
        win_last <= in_last;
      if (emit)
        win_index <= cnt_q;
    end
  end

endmodule

// File: tb/tb_ap_window_feeder.sv
// Directed vector bench for ap_window_feeder.
// Table of per-cycle vectors plus a reset sequence.
module tb_ap_window_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        win_valid;
  logic        win_ready = 1'b0;
  logic [7:0]  A, B, C, D, E, F, G;
  logic        win_last;
  logic [15:0] win_index;
  logic        short_frame;
  logic [55:0] win;

  assign win = {A, B, C, D, E, F, G};

  ap_window_feeder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .win_valid(win_valid), .win_ready(win_ready),
    .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G),
    .win_last(win_last), .win_index(win_index),
    .short_frame(short_frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        iv;
    logic [7:0]  d;
    logic        last;
    logic        wr;
    logic        rdy;
    logic        wv;
    logic        wl;
    logic [15:0] idx;
    logic        sf;
    logic        cw;
    logic [55:0] w;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic vec_t mk(
    input int c, input int iv, input int d,
    input int l, input int wr, input int rdy,
    input int wv, input int wl, input int idx,
    input int sf, input int cw, input logic [55:0] w
  );
    vec_t r;
    r.clr  = (c != 0);
    r.iv   = (iv != 0);
    r.d    = 8'(d);
    r.last = (l != 0);
    r.wr   = (wr != 0);
    r.rdy  = (rdy != 0);
    r.wv   = (wv != 0);
    r.wl   = (wl != 0);
    r.idx  = 16'(idx);
    r.sf   = (sf != 0);
    r.cw   = (cw != 0);
    r.w    = w;
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic step(input logic c, input logic iv,
                      input logic [7:0] d,
                      input logic l, input logic wr);
    @(negedge clk);
    clear     = c;
    in_valid  = iv;
    in_data   = d;
    in_last   = l;
    win_ready = wr;
  endtask

  task automatic push7(input logic [7:0] base,
                       input logic [55:0] w);
    for (int i = 0; i < 7; i++) begin
      step(1'b0, 1'b1, base + 8'(i), 1'b0, 1'b1);
      @(posedge clk);
      #1;
      if (i < 6) begin
        chk("fill_wv", 64'(win_valid), 64'(0));
      end else begin
        chk("full_wv", 64'(win_valid), 64'(1));
        chk("full_win", 64'(win), 64'(w));
        chk("full_idx", 64'(win_index), 64'(0));
      end
    end
  endtask

  initial begin
    // first window
    tbl.push_back(mk(0,1,'h03,0,1, 1,0,0,0,0,1,56'h03));
    tbl.push_back(mk(0,1,'h05,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h07,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h09,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h0B,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h0D,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h0F,0,1, 1,1,0,0,0,1,
                     56'h03_05_07_09_0B_0D_0F));
    // slide with frame end
    tbl.push_back(mk(0,1,'h11,1,1, 1,1,1,1,0,1,
                     56'h05_07_09_0B_0D_0F_11));
    // next frame restarts at index 0
    tbl.push_back(mk(0,1,'h30,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h31,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h32,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h33,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h34,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h35,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h36,0,1, 1,1,0,0,0,1,
                     56'h30_31_32_33_34_35_36));
    // backpressure holds window and stalls input
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,1,'h20,0,0, 0,1,0,0,0,1,
                       56'h30_31_32_33_34_35_36));
    tbl.push_back(mk(0,1,'h20,0,1, 1,1,0,1,0,1,
                     56'h31_32_33_34_35_36_20));
    tbl.push_back(mk(0,1,'h21,1,1, 1,1,1,2,0,1,
                     56'h32_33_34_35_36_20_21));
    // short frame
    tbl.push_back(mk(0,1,'h01,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h02,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h03,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h04,1,1, 1,0,0,0,1,1,
                     56'h36_20_21_01_02_03_04));
    tbl.push_back(mk(0,1,'h0A,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h0B,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h0C,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h0D,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h0E,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h0F,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h10,1,1, 1,1,1,0,0,1,
                     56'h0A_0B_0C_0D_0E_0F_10));
    tbl.push_back(mk(0,0,'h00,0,1, 1,0,0,0,0,0,56'h0));
    // clear mid-fill drops the sample, keeps A..G
    tbl.push_back(mk(0,1,'h40,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h41,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h42,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h43,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h44,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(1,1,'h45,0,1, 0,0,0,0,0,1,
                     56'h0F_10_40_41_42_43_44));
    tbl.push_back(mk(0,1,'h50,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h51,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h52,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h53,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h54,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h55,0,1, 1,0,0,0,0,0,56'h0));
    tbl.push_back(mk(0,1,'h56,0,1, 1,1,0,0,0,1,
                     56'h50_51_52_53_54_55_56));
    // clear drops a pending window
    tbl.push_back(mk(0,0,'h00,0,0, 0,1,0,0,0,1,
                     56'h50_51_52_53_54_55_56));
    tbl.push_back(mk(1,0,'h00,0,0, 0,0,0,0,0,1,
                     56'h50_51_52_53_54_55_56));
    tbl.push_back(mk(0,0,'h00,0,0, 1,0,0,0,0,0,56'h0));

    // reset values
    #1;
    chk("rst_rdy", 64'(in_ready), 64'(0));
    chk("rst_wv", 64'(win_valid), 64'(0));
    chk("rst_win", 64'(win), 64'(0));
    chk("rst_idx", 64'(win_index), 64'(0));
    chk("rst_sf", 64'(short_frame), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[k]) begin
      step(tbl[k].clr, tbl[k].iv, tbl[k].d,
           tbl[k].last, tbl[k].wr);
      #1;
      chk($sformatf("v%0d_rdy", k),
          64'(in_ready), 64'(tbl[k].rdy));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_wv", k),
          64'(win_valid), 64'(tbl[k].wv));
      chk($sformatf("v%0d_sf", k),
          64'(short_frame), 64'(tbl[k].sf));
      if (tbl[k].wv) begin
        chk($sformatf("v%0d_wl", k),
            64'(win_last), 64'(tbl[k].wl));
        chk($sformatf("v%0d_idx", k),
            64'(win_index), 64'(tbl[k].idx));
      end
      if (tbl[k].cw)
        chk($sformatf("v%0d_win", k),
            64'(win), 64'(tbl[k].w));
    end

    // async reset with a pending window
    push7(8'h60, 56'h60_61_62_63_64_65_66);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("pre_rst_wv", 64'(win_valid), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_wv", 64'(win_valid), 64'(0));
    chk("arst_win", 64'(win), 64'(0));
    chk("arst_idx", 64'(win_index), 64'(0));
    chk("arst_rdy", 64'(in_ready), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    chk("hold_rst_wv", 64'(win_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    push7(8'h70, 56'h70_71_72_73_74_75_76);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_cmp, n_err);
    $finish;
  end

endmodule
